// File: rtl/nn_seq_pkg.sv
// rtl/nn_seq_pkg.sv - shared types and helpers for the frame sequencer
// Contents: state_e (sequencer states), ceil_bytes (bits -> whole bytes),
//           cnt_w (counter width for n values, never below 1 bit).
package nn_seq_pkg;

    typedef enum logic [2:0] {
        S_RECV  = 3'd0,
        S_CHK   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_SEND  = 3'd4
    } state_e;

    function automatic int ceil_bytes(input int bits);
        return (bits + 7) / 8;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nn_seq_byte_ser.sv
// rtl/nn_seq_byte_ser.sv - result byte serialiser with valid/ready transmit handshake
// Ports: clk, rst (sync, active-high); load/result capture a new result and start sending;
//        tx_valid/tx_data/tx_ready transmit handshake; done pulses (comb) on the last accept.
// Optional: NN_SEQ_CHECKSUM_EN appends the XOR of the result bytes as a trailing byte.
module nn_seq_byte_ser
    import nn_seq_pkg::*;
#(
    parameter int RES_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [RES_W-1:0] result,
    input  logic             tx_ready,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    output logic             done
);

    localparam int RBY = ceil_bytes(RES_W);
`ifdef NN_SEQ_CHECKSUM_EN
    localparam int NB  = RBY + 1;
`else
    localparam int NB  = RBY;
`endif
    localparam int IW  = cnt_w(NB);

    logic [NB*8-1:0]  sh_q, sh_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [RBY*8-1:0] padded;
    logic [NB*8-1:0]  load_word;
    logic             accept;
    logic             last;

    always_comb begin
        padded = '0;
        padded[RES_W-1:0] = result;
    end

`ifdef NN_SEQ_CHECKSUM_EN
    logic [7:0] csum;

    always_comb begin
        csum = '0;
        for (int i = 0; i < RBY; i++) begin
            csum = csum ^ padded[i*8 +: 8];
        end
        load_word = {csum, padded};
    end
`else
    always_comb begin
        load_word = padded;
    end
`endif

    assign accept = valid_q && tx_ready;
    assign last   = (idx_q == IW'(NB - 1));

    // The byte on tx_data is always sh_q[7:0]; after each accept the register
    // shifts so the next byte is presented on the following cycle.
    always_comb begin
        sh_d    = sh_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (load) begin
            sh_d    = load_word;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (accept) begin
            if (last) begin
                valid_d = 1'b0;
            end else begin
                sh_d  = sh_q >> 8;
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign tx_valid = valid_q;
    assign tx_data  = sh_q[7:0];
    assign done     = accept && last;

endmodule

// File: rtl/nn_frame_sequencer.sv
// rtl/nn_frame_sequencer.sv - UART-side frame assembler and result sender for the network core
// Ports: clk, rst (sync, active-high); rx_valid/rx_data received bytes; frame_data assembled
//        words (word k at [k*WORD_W +: WORD_W]); net_start/net_done/net_result network handshake;
//        tx_valid/tx_data/tx_ready result bytes out; busy (not in RECV); rx_drop, frame_err pulses.
// Optional: NN_SEQ_CHECKSUM_EN adds an XOR trailer byte on receive (checked in S_CHK) and on send.
module nn_frame_sequencer
    import nn_seq_pkg::*;
#(
    parameter int NUM_WORDS    = 9,
    parameter int WORD_W       = 32,
    parameter int RES_W        = 8,
    parameter int IDLE_TIMEOUT = 100000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_data,
    output logic [NUM_WORDS*WORD_W-1:0] frame_data,
    output logic                        net_start,
    input  logic                        net_done,
    input  logic [RES_W-1:0]            net_result,
    output logic                        tx_valid,
    output logic [7:0]                  tx_data,
    input  logic                        tx_ready,
    output logic                        busy,
    output logic                        rx_drop,
    output logic                        frame_err
);

    localparam int BPW        = ceil_bytes(WORD_W);
    localparam int WCW        = cnt_w(NUM_WORDS);
    localparam int BCW        = cnt_w(BPW);
    localparam int TCW        = cnt_w(IDLE_TIMEOUT + 1);
    localparam bit TIMEOUT_ON = (IDLE_TIMEOUT != 0);
    localparam int TO_LAST    = TIMEOUT_ON ? IDLE_TIMEOUT - 1 : 0;

    state_e                      state_q, state_d;
    logic [WCW-1:0]              w_q, w_d;
    logic [BCW-1:0]              b_q, b_d;
    logic [TCW-1:0]              to_q, to_d;
    logic [NUM_WORDS*WORD_W-1:0] frame_q, frame_d;
    logic                        net_start_q, net_start_d;
    logic                        rx_drop_q, rx_drop_d;
    logic                        frame_err_q, frame_err_d;
    logic [BPW*8-1:0]            wtmp;

    logic rx_take;
    logic trl_pend;
    logic store_byte;
    logic last_byte;
    logic partial;
    logic timeout_hit;
    logic ser_load;
    logic ser_done;

    assign rx_take     = rx_valid && (state_q == S_RECV);
    assign store_byte  = rx_take && !trl_pend;
    assign last_byte   = store_byte && (w_q == WCW'(NUM_WORDS - 1)) && (b_q == BCW'(BPW - 1));
    assign partial     = (w_q != '0) || (b_q != '0) || trl_pend;
    // A byte arriving on the expiry cycle takes precedence, hence !rx_valid.
    assign timeout_hit = TIMEOUT_ON && (state_q == S_RECV) && !rx_valid && partial &&
                         (to_q == TCW'(TO_LAST));

`ifdef NN_SEQ_CHECKSUM_EN
    logic       trl_q, trl_d;
    logic [7:0] xor_q, xor_d;
    logic [7:0] chk_q, chk_d;
    logic       chk_ok;

    assign trl_pend = trl_q;
    assign chk_ok   = (chk_q == xor_q);

    // trl_q marks "payload complete, trailer byte still to come".
    always_comb begin
        trl_d = trl_q;
        xor_d = xor_q;
        chk_d = chk_q;
        if (rx_take && trl_q) begin
            chk_d = rx_data;
            trl_d = 1'b0;
        end else if (store_byte) begin
            xor_d = xor_q ^ rx_data;
            if (last_byte) begin
                trl_d = 1'b1;
            end
        end else if (timeout_hit) begin
            trl_d = 1'b0;
            xor_d = '0;
        end
        if (state_q == S_CHK) begin
            xor_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trl_q <= 1'b0;
            xor_q <= '0;
            chk_q <= '0;
        end else begin
            trl_q <= trl_d;
            xor_q <= xor_d;
            chk_q <= chk_d;
        end
    end
`else
    assign trl_pend = 1'b0;
`endif

    // Frame assembly: little-endian bytes into word w_q, bits above WORD_W dropped.
    always_comb begin
        frame_d = frame_q;
        w_d     = w_q;
        b_d     = b_q;
        to_d    = to_q;
        wtmp    = '0;
        if (state_q == S_RECV) begin
            if (rx_valid) begin
                to_d = '0;
                if (store_byte) begin
                    for (int k = 0; k < NUM_WORDS; k++) begin
                        if (w_q == WCW'(k)) begin
                            wtmp = '0;
                            wtmp[WORD_W-1:0] = frame_q[k*WORD_W +: WORD_W];
                            wtmp[{b_q, 3'b000} +: 8] = rx_data;
                            frame_d[k*WORD_W +: WORD_W] = wtmp[WORD_W-1:0];
                        end
                    end
                    if (b_q == BCW'(BPW - 1)) begin
                        b_d = '0;
                        if (w_q == WCW'(NUM_WORDS - 1)) begin
                            w_d = '0;
                        end else begin
                            w_d = w_q + 1'b1;
                        end
                    end else begin
                        b_d = b_q + 1'b1;
                    end
                end
            end else if (timeout_hit) begin
                w_d  = '0;
                b_d  = '0;
                to_d = '0;
            end else if (TIMEOUT_ON && partial) begin
                to_d = to_q + 1'b1;
            end
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RECV: begin
`ifdef NN_SEQ_CHECKSUM_EN
                if (rx_take && trl_q) begin
                    state_d = S_CHK;
                end
`else
                if (last_byte) begin
                    state_d = S_START;
                end
`endif
            end
`ifdef NN_SEQ_CHECKSUM_EN
            S_CHK:   state_d = chk_ok ? S_START : S_RECV;
`endif
            S_START: state_d = S_WAIT;
            S_WAIT:  state_d = net_done ? S_SEND : S_WAIT;
            S_SEND:  state_d = ser_done ? S_RECV : S_SEND;
            default: state_d = S_RECV;
        endcase
    end

    // FSM outputs; the pulse outputs are registered one cycle later.
    always_comb begin
        busy        = (state_q != S_RECV);
        net_start_d = (state_q == S_START);
        rx_drop_d   = rx_valid && (state_q != S_RECV);
        ser_load    = (state_q == S_WAIT) && net_done;
`ifdef NN_SEQ_CHECKSUM_EN
        frame_err_d = timeout_hit || ((state_q == S_CHK) && !chk_ok);
`else
        frame_err_d = timeout_hit;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RECV;
            w_q         <= '0;
            b_q         <= '0;
            to_q        <= '0;
            frame_q     <= '0;
            net_start_q <= 1'b0;
            rx_drop_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            b_q         <= b_d;
            to_q        <= to_d;
            frame_q     <= frame_d;
            net_start_q <= net_start_d;
            rx_drop_q   <= rx_drop_d;
            frame_err_q <= frame_err_d;
        end
    end

    nn_seq_byte_ser #(
        .RES_W (RES_W)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .result   (net_result),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .done     (ser_done)
    );

    assign frame_data = frame_q;
    assign net_start  = net_start_q;
    assign rx_drop    = rx_drop_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_nn_frame_sequencer.sv
// tb/tb_nn_frame_sequencer.sv - self-checking bench for nn_frame_sequencer
module tb_nn_frame_sequencer;

`ifdef NN_SEQ_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int NW   = 9;
    localparam int NBY  = 36;
    localparam int TO   = 20;
    localparam int NTX  = 1 + CS;
    localparam int NTXB = 2 + CS;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_valid, net_done, tx_ready;
    logic [7:0]   rx_data, net_result;
    logic [287:0] frame_data;
    logic         net_start, tx_valid, busy, rx_drop, frame_err;
    logic [7:0]   tx_data;

    logic         b_rx_valid, b_net_done, b_tx_ready;
    logic [7:0]   b_rx_data;
    logic [15:0]  b_net_result;
    logic [23:0]  b_frame_data;
    logic         b_net_start, b_tx_valid, b_busy, b_rx_drop, b_frame_err;
    logic [7:0]   b_tx_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nn_frame_sequencer #(.NUM_WORDS(9), .WORD_W(32), .RES_W(8), .IDLE_TIMEOUT(TO)) dut_a (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .frame_data(frame_data), .net_start(net_start), .net_done(net_done),
        .net_result(net_result), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .busy(busy), .rx_drop(rx_drop), .frame_err(frame_err));

    nn_frame_sequencer #(.NUM_WORDS(2), .WORD_W(12), .RES_W(16), .IDLE_TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst), .rx_valid(b_rx_valid), .rx_data(b_rx_data),
        .frame_data(b_frame_data), .net_start(b_net_start), .net_done(b_net_done),
        .net_result(b_net_result), .tx_valid(b_tx_valid), .tx_data(b_tx_data),
        .tx_ready(b_tx_ready), .busy(b_busy), .rx_drop(b_rx_drop), .frame_err(b_frame_err));

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model of dut_a: byte position in frame, words as integers, tx byte queue.
    int          m_phase;   // 0 receive, 1 check, 2 start, 3 wait, 4 send
    int          m_pos, m_idle;
    bit          m_trl, m_live = 0;
    logic [31:0] m_words [NW];
    logic [7:0]  m_xor, m_trl_byte;
    logic [7:0]  m_txq [$];
    bit          e_start, e_drop, e_err;

    always @(posedge clk) begin
        e_start = 0; e_drop = 0; e_err = 0;
        if (rst) begin
            m_phase = 0; m_pos = 0; m_idle = 0; m_trl = 0; m_xor = 0;
            for (int k = 0; k < NW; k++) m_words[k] = 0;
            m_txq.delete();
        end else begin
            if (rx_valid && m_phase != 0) e_drop = 1;
            case (m_phase)
                0: if (rx_valid) begin
                    m_idle = 0;
                    if (m_trl) begin
                        m_trl = 0; m_trl_byte = rx_data; m_phase = 1;
                    end else begin
                        m_words[m_pos / 4] = (m_words[m_pos / 4] & ~(32'hFF << (8 * (m_pos % 4))))
                                           | (32'(rx_data) << (8 * (m_pos % 4)));
                        m_xor = m_xor ^ rx_data;
                        m_pos++;
                        if (m_pos == NBY) begin
                            m_pos = 0;
                            if (CS != 0) m_trl = 1; else m_phase = 2;
                        end
                    end
                end else if (m_pos != 0 || m_trl) begin
                    m_idle++;
                    if (m_idle == TO) begin
                        m_idle = 0; m_pos = 0; m_trl = 0; m_xor = 0; e_err = 1;
                    end
                end
                1: begin
                    if (m_trl_byte == m_xor) m_phase = 2;
                    else begin e_err = 1; m_phase = 0; end
                    m_xor = 0;
                end
                2: begin e_start = 1; m_phase = 3; end
                3: if (net_done) begin
                    m_txq.push_back(net_result);
                    if (CS != 0) m_txq.push_back(net_result);
                    m_phase = 4;
                end
                4: if (tx_ready) begin
                    void'(m_txq.pop_front());
                    if (m_txq.size() == 0) m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end
        m_live = 1;
    end

    function automatic logic [287:0] exp_frame();
        logic [287:0] f;
        for (int k = 0; k < NW; k++) f[k*32 +: 32] = m_words[k];
        return f;
    endfunction

    always @(negedge clk) begin
        if (m_live) begin
            chk("busy", busy, m_phase != 0);
            chk("tx_valid", tx_valid, m_phase == 4);
            if (m_phase == 4) chk("tx_data", tx_data, m_txq[0]);
            chk("net_start", net_start, e_start);
            chk("rx_drop", rx_drop, e_drop);
            chk("frame_err", frame_err, e_err);
            chk("frame_data", frame_data, exp_frame());
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1; rx_data = b; cyc(); rx_valid = 0;
    endtask

    task automatic send_payload(input logic [7:0] base);
        for (int i = 0; i < NBY; i++) send_byte(base + 8'(i));
    endtask

    function automatic logic [7:0] payload_xor(input logic [7:0] base);
        logic [7:0] x = 0;
        for (int i = 0; i < NBY; i++) x = x ^ (base + 8'(i));
        return x;
    endfunction

    task automatic send_frame(input logic [7:0] base, output int lat);
        send_payload(base);
        if (CS != 0) send_byte(payload_xor(base));
        lat = 1;
        while (!net_start && lat < 20) begin cyc(); lat++; end
    endtask

    task automatic result(input logic [7:0] r);
        net_result = r; net_done = 1; cyc(); net_done = 0;
    endtask

    task automatic drain(input string name);
        int xfers = 0;
        int n = 0;
        tx_ready = 1;
        while (busy && n < 20) begin
            if (tx_valid) xfers++;
            cyc(); n++;
        end
        tx_ready = 0;
        chk({name, "_xfers"}, xfers, NTX);
        chk({name, "_busy_after"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, n, nc, nst;
        logic [7:0] cap [4];
        rst = 1; rx_valid = 0; rx_data = 0; net_done = 0; net_result = 0; tx_ready = 0;
        b_rx_valid = 0; b_rx_data = 0; b_net_done = 0; b_net_result = 0; b_tx_ready = 0;
        repeat (3) cyc();
        rst = 0;
        chk("reset_frame", frame_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_tx_valid", tx_valid, 0);
        chk("reset_net_start", net_start, 0);
        chk("reset_frame_err", frame_err, 0);

        // frame 0x00..0x23
        send_frame(8'h00, lat);
        chk("start_latency", lat, 2 + CS);
        chk("word0", frame_data[31:0], 32'h03020100);
        chk("word8", frame_data[287:256], 32'h23222120);

        // bytes during WAIT are dropped
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hEE);
            chk("drop_pulse", rx_drop, 1);
        end
        chk("word0_frozen", frame_data[31:0], 32'h03020100);

        // result with back-pressure
        result(8'hA5);
        for (int i = 0; i < 5; i++) begin
            chk("hold_tx_valid", tx_valid, 1);
            chk("hold_tx_data", tx_data, 8'hA5);
            cyc();
        end
        drain("a5");

        // byte arriving exactly at expiry wins, then the partial frame times out
        send_byte(8'h10);
        repeat (TO - 1) cyc();
        send_byte(8'h11);
        chk("expiry_byte_wins", frame_err, 0);
        n = 0;
        while (!frame_err && n < 60) begin cyc(); n++; end
        chk("timeout_cycles", n, TO);
        chk("partial_word0", frame_data[31:0], 32'h03021110);

        // five bytes then timeout, next frame restarts at word0 byte0
        for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i));
        n = 0;
        while (!frame_err && n < 60) begin cyc(); n++; end
        chk("timeout5_cycles", n, TO);
        chk("t5_word0", frame_data[31:0], 32'h53525150);
        chk("t5_word1", frame_data[63:32], 32'h07060554);
        send_frame(8'h60, lat);
        chk("resync_latency", lat, 2 + CS);
        chk("resync_word0", frame_data[31:0], 32'h63626160);
        chk("resync_word8", frame_data[287:256], 32'h83828180);
        tx_ready = 1;
        cyc();
        result(8'h3C);
        drain("3c");

        // reset during SEND abandons the byte
        send_frame(8'h90, lat);
        result(8'h77);
        repeat (2) cyc();
        rst = 1; cyc(); rst = 0;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame", frame_data, 0);

`ifdef NN_SEQ_CHECKSUM_EN
        send_payload(8'hB0);
        send_byte(payload_xor(8'hB0) ^ 8'h01);
        cyc();
        chk("bad_trl_err", frame_err, 1);
        nst = 0;
        for (int i = 0; i < 6; i++) begin nst += int'(net_start); cyc(); end
        chk("bad_trl_no_start", nst, 0);
        send_frame(8'hC0, lat);
        chk("good_trl_latency", lat, 3);
        result(8'h5A);
        drain("cs5a");
`endif

        // dut_b: 12-bit words, 16-bit result
        b_rx_valid = 1;
        b_rx_data = 8'hFF; cyc();
        b_rx_data = 8'hFF; cyc();
        b_rx_data = 8'hAB; cyc();
        b_rx_data = 8'hCD; cyc();
        if (CS != 0) begin b_rx_data = 8'h66; cyc(); end
        b_rx_valid = 0;
        n = 0;
        while (!b_net_start && n < 20) begin cyc(); n++; end
        chk("b_start_seen", b_net_start, 1);
        chk("b_word0", b_frame_data[11:0], 12'hFFF);
        chk("b_word1", b_frame_data[23:12], 12'hDAB);
        b_net_result = 16'h1234; b_net_done = 1; cyc(); b_net_done = 0;
        b_tx_ready = 1;
        nc = 0; n = 0;
        while (b_busy && n < 20) begin
            if (b_tx_valid && nc < 4) begin cap[nc] = b_tx_data; nc++; end
            cyc(); n++;
        end
        b_tx_ready = 0;
        chk("b_tx_count", nc, NTXB);
        chk("b_tx0", cap[0], 8'h34);
        chk("b_tx1", cap[1], 8'h12);
        if (CS != 0) chk("b_tx2", cap[2], 8'h26);

        repeat (3) cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
